// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX byte interface between two requesters, with burst-based grants.
// Optional stalled-requester release is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_last,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req1_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic [1:0] o_grant,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  if (MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arb: illegal MAX_BURST or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t         state, state_next;
  logic           last_served;
  logic [CW-1:0]  burst_cnt;
  logic           tx_valid;
  logic [7:0]     tx_data;

  logic           free;
  logic           ready0, ready1;
  logic           grant_valid;
  logic           acc;
  logic [7:0]     acc_data;
  logic           acc_last;
  logic           burst_done;
  logic           timeout;
  logic           release_gnt;

  always_comb begin
    free        = ~tx_valid | i_tx_ready;
    ready0      = (state == GNT0) & free;
    ready1      = (state == GNT1) & free;
    grant_valid = ((state == GNT0) & i_req0_valid) | ((state == GNT1) & i_req1_valid);
    acc         = (i_req0_valid & ready0) | (i_req1_valid & ready1);
    // Only the granted requester's byte ever reaches the output mux.
    acc_data    = (state == GNT1) ? i_req1_data : i_req0_data;
    acc_last    = (state == GNT1) ? i_req1_last : i_req0_last;
    burst_done  = (burst_cnt == CW'(MAX_BURST - 1));
    release_gnt = (acc & (acc_last | burst_done)) | timeout;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_cnt;

  // Only cycles with the granted requester's valid low count; backpressure stalls keep valid high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE || grant_valid || release_gnt) begin
      stall_cnt <= '0;
    end else if (stall_cnt != SW'(TIMEOUT_CYCLES)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) & ~grant_valid & (stall_cnt == SW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_req0_valid && i_req1_valid) state_next = last_served ? GNT0 : GNT1;
        else if (i_req0_valid)            state_next = GNT0;
        else if (i_req1_valid)            state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (release_gnt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
    end else begin
      state <= state_next;
      if (release_gnt) begin
        last_served <= (state == GNT1);
        burst_cnt   <= '0;
      end else if (acc) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (acc) begin
      tx_valid <= 1'b1;
      tx_data  <= acc_data;
    end else if (i_tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  assign o_req0_ready = ready0;
  assign o_req1_ready = ready1;
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = tx_data;
  assign o_grant      = {state == GNT1, state == GNT0};
  assign o_busy       = (state != IDLE) | tx_valid;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed latency/reset/stall cases plus a randomized
// two-requester run checked against a segment-level round-robin model of the output byte stream.
module tb_uart_tx_arb;

  localparam int unsigned MB = 4;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, l0, v1, l1;
  logic [7:0] d0, d1;
  logic       rdy0, rdy1;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req0_data(d0), .i_req0_last(l0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_data(d1), .i_req1_last(l1), .o_req1_ready(rdy1),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .o_grant(grant), .o_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    v0 = 0; l0 = 0; d0 = '0;
    v1 = 0; l1 = 0; d1 = '0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [8:0] q0[$], q1[$];
  int         seg0[$], seg1[$];
  logic [7:0] exp_q[$];

  task automatic build_stream(input int r);
    int seq = 0;
    int cnt = 0;
    int nmsg = $urandom_range(3, 6);
    for (int m = 0; m < nmsg; m++) begin
      int len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        logic [8:0] b;
        logic       last = (k == len - 1);
        b = {last, r[0], 7'(seq)};
        seq++;
        cnt++;
        if (r == 0) q0.push_back(b); else q1.push_back(b);
        if (last || cnt == int'(MB)) begin
          if (r == 0) seg0.push_back(cnt); else seg1.push_back(cnt);
          cnt = 0;
        end
      end
    end
  endtask

  // Round robin at segment granularity: after a segment, the other requester goes next if it has data.
  task automatic build_expected();
    int s0 = 0, s1 = 0, b0 = 0, b1 = 0, turn = 0, r;
    while (s0 < seg0.size() || s1 < seg1.size()) begin
      r = turn;
      if (r == 0 && s0 >= seg0.size()) r = 1;
      if (r == 1 && s1 >= seg1.size()) r = 0;
      if (r == 0) begin
        for (int k = 0; k < seg0[s0]; k++) exp_q.push_back(q0[b0 + k][7:0]);
        b0 += seg0[s0]; s0++;
      end else begin
        for (int k = 0; k < seg1[s1]; k++) exp_q.push_back(q1[b1 + k][7:0]);
        b1 += seg1[s1]; s1++;
      end
      turn = 1 - r;
    end
  endtask

  initial begin
    // Reset values
    reset_dut();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy0", rdy0, 0);

    // Single requester latency: 0x41,0x42,0x43
    @(posedge clk); #1;
    tx_ready = 1; v0 = 1; d0 = 8'h41; l0 = 0;
    check("lat_c0_grant", grant, 2'b00);
    check("lat_c0_rdy0", rdy0, 0);
    @(posedge clk); #1;
    check("lat_c1_grant", grant, 2'b01);
    check("lat_c1_rdy0", rdy0, 1);
    check("lat_c1_txv", tx_valid, 0);
    @(posedge clk); #1;
    check("lat_c2_txv", tx_valid, 1);
    check("lat_c2_data", tx_data, 8'h41);
    d0 = 8'h42;
    @(posedge clk); #1;
    check("lat_c3_data", tx_data, 8'h42);
    d0 = 8'h43; l0 = 1;
    @(posedge clk); #1;
    check("lat_c4_data", tx_data, 8'h43);
    check("lat_c4_grant", grant, 2'b00);
    v0 = 0; l0 = 0;
    @(posedge clk); #1;
    check("lat_c5_txv", tx_valid, 0);
    check("lat_c5_busy", busy, 0);

    // Reset mid-burst with a byte held under backpressure
    reset_dut();
    @(posedge clk); #1;
    v0 = 1; d0 = 8'h55; l0 = 0; tx_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rm_pre_txv", tx_valid, 1);
    check("rm_pre_rdy0", rdy0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rm_txv", tx_valid, 0);
    check("rm_grant", grant, 0);
    check("rm_busy", busy, 0);
    v1 = 1; d1 = 8'hAA; l1 = 1; l0 = 1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_tie_grant", grant, 2'b01);

    // Stalled requester holding the grant
    reset_dut();
    @(posedge clk); #1;
    tx_ready = 1; v0 = 1; d0 = 8'h10; l0 = 0; v1 = 1; d1 = 8'h90; l1 = 1;
    @(posedge clk); #1;
    check("st_grant0", grant, 2'b01);
    @(posedge clk); #1;
    check("st_data", tx_data, 8'h10);
    v0 = 0;
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int lat = -1;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (grant == 2'b10) begin lat = i; break; end
      end
      check("st_timeout_window", (lat >= int'(TO) && lat <= int'(TO) + 4), 1);
    end
`else
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (rdy1) seen++;
      end
      check("st_rdy1_blocked", seen, 0);
      check("st_grant_held", grant, 2'b01);
      v0 = 1; d0 = 8'h11; l0 = 1;
      @(posedge clk); #1;
      v0 = 0; l0 = 0;
      check("st_resume_data", tx_data, 8'h11);
      check("st_release_grant", grant, 2'b00);
      @(posedge clk); #1;
      check("st_grant1", grant, 2'b10);
    end
`endif

    // Randomized two-requester run with random backpressure
    reset_dut();
    build_stream(0);
    build_stream(1);
    build_expected();
    begin
      int p0 = 0, p1 = 0, taken = 0, total, cyc = 0;
      logic a0, a1;
      logic [1:0] prev_grant = 2'b00;
      total = q0.size() + q1.size();
      @(posedge clk); #1;
      forever begin
        v0 = (p0 < q0.size());
        if (v0) {l0, d0} = {q0[p0][8], q0[p0][7:0]};
        v1 = (p1 < q1.size());
        if (v1) {l1, d1} = {q1[p1][8], q1[p1][7:0]};
        tx_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        check("rnd_rdy0", rdy0, grant[0] & (~tx_valid | tx_ready));
        check("rnd_rdy1", rdy1, grant[1] & (~tx_valid | tx_ready));
        check("rnd_busy", busy, (grant != 2'b00) | tx_valid);
        check("rnd_idle_gap", (prev_grant != 0 && grant != 0 && prev_grant != grant), 0);
        prev_grant = grant;
        a0 = v0 & rdy0;
        a1 = v1 & rdy1;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("rnd_extra_byte", 1, 0);
          end else begin
            check("rnd_byte", tx_data, exp_q.pop_front());
          end
          taken++;
        end
        if (taken >= total) break;
        cyc++;
        if (cyc > 5000) begin
          check("rnd_cycle_budget", taken, total);
          break;
        end
        @(posedge clk); #1;
        if (a0) p0++;
        if (a1) p1++;
      end
      check("rnd_drained", exp_q.size(), 0);
      v0 = 0; v1 = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
